// File: rtl/mpc_chan_arb.sv
// Round-robin arbiter sharing one MPC request/response port among NumChan channels.
// An in-order ID FIFO steers each response back to the channel that issued the request.
package mpc_chan_arb_pkg;

    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned ReqDataWidth = 128;

    typedef enum logic {
        MPC_LOAD  = 1'b0,
        MPC_STORE = 1'b1
    } mpc_op_e;

    typedef struct packed {
        mpc_op_e                 op;
        logic [AddrWidth-1:0]    addr;
        logic [ReqDataWidth-1:0] wdata;
    } channel_req_t;

endpackage

module mpc_chan_arb
    import mpc_chan_arb_pkg::*;
#(
    parameter int unsigned NumChan   = 3,
    parameter int unsigned IdDepth   = 16,
    parameter int unsigned DataWidth = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NumChan-1:0]         chan_req_valid,
    output logic [NumChan-1:0]         chan_req_ready,
    input  channel_req_t               chan_req [NumChan],
    output logic [NumChan-1:0]         chan_rsp_valid,
    input  logic [NumChan-1:0]         chan_rsp_ready,
    output logic [DataWidth-1:0]       chan_rsp_rdata,
    output logic                       mpc_req_valid,
    input  logic                       mpc_req_ready,
    output channel_req_t               mpc_req,
    input  logic                       mpc_rsp_valid,
    output logic                       mpc_rsp_ready,
    input  logic [DataWidth-1:0]       mpc_rsp_rdata,
    output logic [$clog2(IdDepth):0]   outstanding,
    output logic                       err_unexp_rsp
);

    localparam int unsigned ChanIdW = $clog2(NumChan);
    localparam int unsigned PtrW    = $clog2(IdDepth);
    localparam int unsigned CntW    = PtrW + 1;

    typedef logic [ChanIdW-1:0] chan_id_t;

    chan_id_t          rr_ptr;
    logic              lock_q;
    chan_id_t          lock_id;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    chan_id_t          id_fifo [IdDepth];

    chan_id_t          arb_grant;
    logic              arb_found;
    int unsigned       idx;
    chan_id_t          grant;
    chan_id_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              req_ok;
    logic              push;
    logic              pop;

    assign fifo_full  = (outstanding == CntW'(IdDepth));
    assign fifo_empty = (outstanding == '0);

    // Cyclic first-valid search starting at rr_ptr
    always_comb begin
        arb_grant = rr_ptr;
        arb_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NumChan; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NumChan) begin
                idx = idx - NumChan;
            end
            if (!arb_found && chan_req_valid[ChanIdW'(idx)]) begin
                arb_found = 1'b1;
                arb_grant = ChanIdW'(idx);
            end
        end
    end

    assign grant   = lock_q ? lock_id : arb_grant;
    assign mpc_req = chan_req[grant];

    // Request side; rst_n gating keeps every handshake output low during reset
    always_comb begin
        req_ok         = rst_n & ~fifo_full;
        mpc_req_valid  = req_ok & (lock_q | (|chan_req_valid));
        chan_req_ready = '0;
        for (int i = 0; i < NumChan; i++) begin
            chan_req_ready[i] = req_ok & mpc_req_ready & (grant == ChanIdW'(i));
        end
    end

    assign head = id_fifo[rd_ptr];

    always_comb begin
        chan_rsp_valid = '0;
        mpc_rsp_ready  = 1'b0;
        for (int i = 0; i < NumChan; i++) begin
            if (head == ChanIdW'(i)) begin
                chan_rsp_valid[i] = rst_n & mpc_rsp_valid & ~fifo_empty;
                mpc_rsp_ready     = rst_n & chan_rsp_ready[i] & ~fifo_empty;
            end
        end
    end

    assign chan_rsp_rdata = mpc_rsp_rdata;

    assign push = mpc_req_valid & mpc_req_ready;
    assign pop  = mpc_rsp_valid & mpc_rsp_ready;

    // ID storage needs no reset: entries are only read between push and pop
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            lock_q        <= 1'b0;
            lock_id       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
                rr_ptr <= (grant == ChanIdW'(NumChan - 1)) ? '0 : grant + ChanIdW'(1);
                lock_q <= 1'b0;
            end else if (mpc_req_valid && !mpc_req_ready) begin
                lock_q  <= 1'b1;
                lock_id <= grant;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end

            if (push && !pop) begin
                outstanding <= outstanding + CntW'(1);
            end else if (pop && !push) begin
                outstanding <= outstanding - CntW'(1);
            end

            if (mpc_rsp_valid && fifo_empty) begin
                err_unexp_rsp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mpc_chan_arb.sv
// Directed bench for mpc_chan_arb: vector table for arbitration and routing,
// plus hand-written sequences for store, lock, full, error and async reset.
module tb_mpc_chan_arb;
    import mpc_chan_arb_pkg::*;

    localparam int unsigned NumChan   = 3;
    localparam int unsigned IdDepth   = 16;
    localparam int unsigned DataWidth = 128;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NumChan-1:0]    chan_req_valid;
    logic [NumChan-1:0]    chan_req_ready;
    channel_req_t          chan_req [NumChan];
    logic [NumChan-1:0]    chan_rsp_valid;
    logic [NumChan-1:0]    chan_rsp_ready;
    logic [DataWidth-1:0]  chan_rsp_rdata;
    logic                  mpc_req_valid;
    logic                  mpc_req_ready;
    channel_req_t          mpc_req;
    logic                  mpc_rsp_valid;
    logic                  mpc_rsp_ready;
    logic [DataWidth-1:0]  mpc_rsp_rdata;
    logic [4:0]            outstanding;
    logic                  err_unexp_rsp;

    mpc_chan_arb #(
        .NumChan   (NumChan),
        .IdDepth   (IdDepth),
        .DataWidth (DataWidth)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .chan_req_valid (chan_req_valid),
        .chan_req_ready (chan_req_ready),
        .chan_req       (chan_req),
        .chan_rsp_valid (chan_rsp_valid),
        .chan_rsp_ready (chan_rsp_ready),
        .chan_rsp_rdata (chan_rsp_rdata),
        .mpc_req_valid  (mpc_req_valid),
        .mpc_req_ready  (mpc_req_ready),
        .mpc_req        (mpc_req),
        .mpc_rsp_valid  (mpc_rsp_valid),
        .mpc_rsp_ready  (mpc_rsp_ready),
        .mpc_rsp_rdata  (mpc_rsp_rdata),
        .outstanding    (outstanding),
        .err_unexp_rsp  (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req_v;
        logic       req_rdy;
        logic       rsp_v;
        logic [2:0] rsp_rdy;
        logic [2:0] exp_req_rdy;
        logic       exp_req_v;
        int         exp_gnt;
        logic [2:0] exp_rsp_v;
        logic       exp_rsp_rdy;
        int         exp_out;
        logic       exp_err;
    } vec_t;

    vec_t         vecs [$];
    channel_req_t pat [NumChan];
    int           n_chk  = 0;
    int           n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rv, input logic rr, input logic sv, input logic [2:0] sr);
        chan_req_valid = rv;
        mpc_req_ready  = rr;
        mpc_rsp_valid  = sv;
        chan_rsp_ready = sr;
    endtask

    // Reset with all handshake inputs active to confirm outputs stay low
    task automatic reset_dut();
        rst_n = 1'b0;
        drive(3'b111, 1'b1, 1'b1, 3'b111);
        #2;
        chk("rst_req_valid", 256'(mpc_req_valid), 256'(0));
        chk("rst_req_ready", 256'(chan_req_ready), 256'(0));
        chk("rst_rsp_valid", 256'(chan_rsp_valid), 256'(0));
        chk("rst_rsp_ready", 256'(mpc_rsp_ready), 256'(0));
        cycle();
        cycle();
        chk("rst_outstanding", 256'(outstanding), 256'(0));
        chk("rst_err", 256'(err_unexp_rsp), 256'(0));
        drive(3'b000, 1'b0, 1'b0, 3'b000);
        rst_n = 1'b1;
    endtask

    initial begin
        pat[0] = '{op: MPC_STORE, addr: 32'hA8,   wdata: 128'haaaabbbbccccdddd};
        pat[1] = '{op: MPC_LOAD,  addr: 32'h1040, wdata: 128'h1111};
        pat[2] = '{op: MPC_STORE, addr: 32'h2080, wdata: 128'h2222_3333};
        for (int i = 0; i < NumChan; i++) chan_req[i] = pat[i];
        mpc_rsp_rdata = '0;

        // Rotation 0,1,2,0,1,2, push+pop together, backpressure, unexpected response
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b001,1'b1, 0, 3'b000,1'b0,1,1'b0});
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b010,1'b1, 1, 3'b000,1'b0,2,1'b0});
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b100,1'b1, 2, 3'b000,1'b0,3,1'b0});
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b001,1'b1, 0, 3'b000,1'b0,4,1'b0});
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b010,1'b1, 1, 3'b000,1'b0,5,1'b0});
        vecs.push_back('{3'b111,1'b1,1'b0,3'b000, 3'b100,1'b1, 2, 3'b000,1'b0,6,1'b0});
        vecs.push_back('{3'b001,1'b1,1'b1,3'b111, 3'b001,1'b1, 0, 3'b001,1'b1,6,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b010,1'b1,5,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b011, 3'b000,1'b0,-1, 3'b100,1'b0,5,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b100,1'b1,4,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b001,1'b1,3,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b010,1'b1,2,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b100,1'b1,1,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b001,1'b1,0,1'b0});
        vecs.push_back('{3'b000,1'b0,1'b1,3'b111, 3'b000,1'b0,-1, 3'b000,1'b0,0,1'b1});
        vecs.push_back('{3'b000,1'b0,1'b0,3'b111, 3'b000,1'b0,-1, 3'b000,1'b0,0,1'b1});

        reset_dut();

        // Single store from ch0, same-cycle pass-through
        drive(3'b001, 1'b1, 1'b0, 3'b000);
        #2;
        chk("st_req_valid", 256'(mpc_req_valid), 256'(1));
        chk("st_req_data", 256'(mpc_req), 256'(pat[0]));
        chk("st_req_ready", 256'(chan_req_ready), 256'(3'b001));
        cycle();
        chk("st_outstanding", 256'(outstanding), 256'(1));
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        #2;
        chk("st_rsp_valid", 256'(chan_rsp_valid), 256'(3'b001));
        chk("st_rsp_ready", 256'(mpc_rsp_ready), 256'(1));
        cycle();
        chk("st_out_drained", 256'(outstanding), 256'(0));

        // rr_ptr is 1 now: ch1 wins over ch0
        drive(3'b011, 1'b1, 1'b0, 3'b111);
        #2;
        chk("rr_after_store", 256'(chan_req_ready), 256'(3'b010));
        cycle();
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        #2;
        chk("rr_rsp_ch1", 256'(chan_rsp_valid), 256'(3'b010));
        cycle();

        // Lock: rr_ptr=2, ch1 stalls, ch0 appears but must not steal the grant
        drive(3'b010, 1'b0, 1'b0, 3'b111);
        #2;
        chk("lk_req_valid", 256'(mpc_req_valid), 256'(1));
        chk("lk_req_data", 256'(mpc_req), 256'(pat[1]));
        chk("lk_req_ready", 256'(chan_req_ready), 256'(0));
        cycle();
        for (int c = 0; c < 2; c++) begin
            drive(3'b011, 1'b0, 1'b0, 3'b111);
            #2;
            chk("lk_hold_data", 256'(mpc_req), 256'(pat[1]));
            chk("lk_hold_valid", 256'(mpc_req_valid), 256'(1));
            cycle();
        end
        chk("lk_no_push", 256'(outstanding), 256'(0));
        drive(3'b011, 1'b1, 1'b0, 3'b111);
        #2;
        chk("lk_accept_ch1", 256'(chan_req_ready), 256'(3'b010));
        chk("lk_accept_data", 256'(mpc_req), 256'(pat[1]));
        cycle();
        chk("lk_out1", 256'(outstanding), 256'(1));
        #2;
        chk("lk_next_ch0", 256'(chan_req_ready), 256'(3'b001));
        cycle();
        chk("lk_out2", 256'(outstanding), 256'(2));
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        #2;
        chk("lk_rsp_ch1", 256'(chan_rsp_valid), 256'(3'b010));
        cycle();
        #2;
        chk("lk_rsp_ch0", 256'(chan_rsp_valid), 256'(3'b001));
        cycle();
        chk("lk_out0", 256'(outstanding), 256'(0));

        // Full: IdDepth pushes, then pop with pending request defers the push
        drive(3'b001, 1'b1, 1'b0, 3'b111);
        repeat (IdDepth) cycle();
        chk("full_out", 256'(outstanding), 256'(IdDepth));
        #2;
        chk("full_req_valid", 256'(mpc_req_valid), 256'(0));
        chk("full_req_ready", 256'(chan_req_ready), 256'(0));
        mpc_rsp_valid = 1'b1;
        #1;
        chk("full_pop_no_push", 256'(mpc_req_valid), 256'(0));
        chk("full_pop_rsp", 256'(chan_rsp_valid), 256'(3'b001));
        chk("full_pop_ready", 256'(mpc_rsp_ready), 256'(1));
        cycle();
        chk("full_out15", 256'(outstanding), 256'(IdDepth - 1));
        mpc_rsp_valid = 1'b0;
        #2;
        chk("full_repush_valid", 256'(mpc_req_valid), 256'(1));
        chk("full_repush_ready", 256'(chan_req_ready), 256'(3'b001));
        cycle();
        chk("full_out16", 256'(outstanding), 256'(IdDepth));
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        for (int i = 0; i < IdDepth; i++) begin
            #2;
            chk("full_drain_rsp", 256'(chan_rsp_valid), 256'(3'b001));
            cycle();
        end
        chk("full_drained", 256'(outstanding), 256'(0));

        // Vector table from a clean reset
        reset_dut();
        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].req_v, vecs[v].req_rdy, vecs[v].rsp_v, vecs[v].rsp_rdy);
            mpc_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
            #2;
            chk($sformatf("v%0d_req_ready", v), 256'(chan_req_ready), 256'(vecs[v].exp_req_rdy));
            chk($sformatf("v%0d_req_valid", v), 256'(mpc_req_valid), 256'(vecs[v].exp_req_v));
            if (vecs[v].exp_gnt >= 0)
                chk($sformatf("v%0d_req_data", v), 256'(mpc_req), 256'(pat[vecs[v].exp_gnt]));
            chk($sformatf("v%0d_rsp_valid", v), 256'(chan_rsp_valid), 256'(vecs[v].exp_rsp_v));
            chk($sformatf("v%0d_rsp_ready", v), 256'(mpc_rsp_ready), 256'(vecs[v].exp_rsp_rdy));
            chk($sformatf("v%0d_rdata", v), 256'(chan_rsp_rdata), 256'(mpc_rsp_rdata));
            cycle();
            chk($sformatf("v%0d_outstanding", v), 256'(outstanding), 256'(vecs[v].exp_out));
            chk($sformatf("v%0d_err", v), 256'(err_unexp_rsp), 256'(vecs[v].exp_err));
        end

        // Async reset mid-traffic with 5 outstanding
        drive(3'b111, 1'b1, 1'b0, 3'b111);
        repeat (5) cycle();
        chk("ar_out5", 256'(outstanding), 256'(5));
        chk("ar_err_sticky", 256'(err_unexp_rsp), 256'(1));
        mpc_rsp_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_outstanding", 256'(outstanding), 256'(0));
        chk("ar_err", 256'(err_unexp_rsp), 256'(0));
        chk("ar_req_valid", 256'(mpc_req_valid), 256'(0));
        chk("ar_req_ready", 256'(chan_req_ready), 256'(0));
        chk("ar_rsp_valid", 256'(chan_rsp_valid), 256'(0));
        chk("ar_rsp_ready", 256'(mpc_rsp_ready), 256'(0));
        cycle();
        rst_n = 1'b1;
        drive(3'b001, 1'b1, 1'b0, 3'b000);
        #2;
        chk("ar_post_ready", 256'(chan_req_ready), 256'(3'b001));
        chk("ar_post_data", 256'(mpc_req), 256'(pat[0]));
        cycle();
        chk("ar_post_out", 256'(outstanding), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
